// File: rtl/serial_paralelo1_pkg.sv
// rtl/serial_paralelo1_pkg.sv - shared constants and state encoding for the serial link receiver
// Purpose: comma character default, lock count default and the receiver FSM state type.
package serial_paralelo1_pkg;

  // Comma/idle character, also sent by the transmitter in place of invalid bytes.
  localparam logic [7:0] BC_CHAR_DEF = 8'hBC;

  // Consecutive aligned commas needed before the link is declared active.
  localparam int BC_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

endpackage

// File: rtl/serial_paralelo1_if.sv
// rtl/serial_paralelo1_if.sv - serial-in / byte-out bundle of the link receiver
// Purpose: groups the serial input and the byte-side outputs.
// Signals: data_in (serial, MSB first), data_out[7:0], valid_out, active.
// Modports: master drives data_in and observes outputs; slave is the receiver.
interface serial_paralelo1_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/serial_paralelo1_sp_framer.sv
// rtl/serial_paralelo1_sp_framer.sv - bit shifter and byte-slot counter of the link receiver
// Purpose: shifts the serial stream in MSB first and marks byte boundaries.
// Ports:
//   clk_32f       bit clock
//   reset         asynchronous active-low reset
//   i_data_in     serial bit sampled this edge
//   i_align_clr   next bit starts a new byte (zeroes the bit counter)
//   i_run         bit counter advances (aligned states only)
//   o_sr_next     last 8 bits including the one sampled this edge
//   o_boundary    this edge samples the LSB of a byte
module sp_framer (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       i_data_in,
  input  logic       i_align_clr,
  input  logic       i_run,
  output logic [7:0] o_sr_next,
  output logic       o_boundary
);

  // Only the newest 7 bits need storing: the oldest of the 8 falls out on
  // every shift, so it is never read.
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;

  assign o_sr_next  = {r_sr, i_data_in};
  assign o_boundary = i_run && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_sr      <= 7'd0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_sr <= o_sr_next[6:0];
      if (i_align_clr) begin
        r_bit_cnt <= 3'd0;
      end else if (i_run) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_paralelo1.sv
// rtl/serial_paralelo1.sv - serial-to-byte receiver with comma alignment and lock
// Purpose: hunts for the comma at any bit offset, locks after BC_LOCK aligned
// commas, then delivers non-comma bytes with a valid flag.
// Ports:
//   clk_32f   bit clock, one bit per rising edge
//   reset     asynchronous active-low reset
//   bus       slave side: data_in in; data_out, valid_out, active out
module serial_paralelo1
  import serial_paralelo1_pkg::*;
#(
  parameter logic [7:0] BC_CHAR = BC_CHAR_DEF,
  parameter int         BC_LOCK = BC_LOCK_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  serial_paralelo1_if.slave bus
);

  localparam logic [2:0] LOCK_CNT = BC_LOCK[2:0];

  sp_state_t  r_state, w_state_n;
  logic [2:0] r_bc_cnt, w_bc_cnt_n;
  logic [7:0] r_data_out, w_data_out_n;
  logic       r_valid_out, w_valid_out_n;
  logic       r_active, w_active_n;

  logic [7:0] w_sr_next;
  logic       w_boundary;
  logic       w_align_clr;
  logic       w_run;
  logic [2:0] w_bc_inc;

  assign w_run    = (r_state != SEARCH);
  assign w_bc_inc = r_bc_cnt + 3'd1;

  sp_framer u_framer (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_data_in   (bus.data_in),
    .i_align_clr (w_align_clr),
    .i_run       (w_run),
    .o_sr_next   (w_sr_next),
    .o_boundary  (w_boundary)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_bc_cnt    <= 3'd0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bc_cnt    <= w_bc_cnt_n;
      r_data_out  <= w_data_out_n;
      r_valid_out <= w_valid_out_n;
      r_active    <= w_active_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_bc_cnt_n    = r_bc_cnt;
    w_data_out_n  = r_data_out;
    w_valid_out_n = r_valid_out;
    w_active_n    = r_active;
    w_align_clr   = 1'b0;

    case (r_state)
      SEARCH: begin
        // Comma found at an arbitrary offset: the next bit is a byte MSB.
        if (w_sr_next == BC_CHAR) begin
          w_align_clr = 1'b1;
          w_bc_cnt_n  = 3'd1;
          if (BC_LOCK == 1) begin
            w_state_n  = ACTIVE;
            w_active_n = 1'b1;
          end else begin
            w_state_n = SYNC;
          end
        end
      end

      SYNC: begin
        if (w_boundary) begin
          if (w_sr_next == BC_CHAR) begin
            w_bc_cnt_n = w_bc_inc;
            if (w_bc_inc == LOCK_CNT) begin
              w_state_n  = ACTIVE;
              w_active_n = 1'b1;
            end
          end else begin
            w_bc_cnt_n = 3'd0;
            w_state_n  = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Alignment is frozen here; commas only mark the slot as invalid.
        if (w_boundary) begin
          if (w_sr_next == BC_CHAR) begin
            w_valid_out_n = 1'b0;
          end else begin
            w_data_out_n  = w_sr_next;
            w_valid_out_n = 1'b1;
          end
        end
      end

      default: begin
        w_state_n = SEARCH;
      end
    endcase
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.active    = r_active;

endmodule
